// File: rtl/protocol_sequencer_core_if.sv
// Program-memory fetch port plus bus-engine request/response channel of the sequencer.
// master = sequencer side, slave = memory / bus-engine side.
interface protocol_sequencer_core_if #(
   parameter int ADDR_W = 8
);
   logic              prog_rd_en;
   logic [ADDR_W-1:0] prog_addr;
   logic [12:0]       prog_rdata;
   logic              xfer_valid;
   logic              xfer_ready;
   logic [3:0]        xfer_cnfg;
   logic [7:0]        xfer_data;
   logic              rsp_valid;
   logic [7:0]        rsp_data;

   modport master (
      output prog_rd_en, prog_addr, xfer_valid, xfer_cnfg, xfer_data,
      input  prog_rdata, xfer_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  prog_rd_en, prog_addr, xfer_valid, xfer_cnfg, xfer_data,
      output prog_rdata, xfer_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/protocol_sequencer_core.sv
// Sequencer execution engine: fetch/decode of 13-bit program words, bus transfer dispatch, control flow.
// 2 cycles per instruction, transfers 3 cycles plus bus latency; xfer request held stable until xfer_ready.
module protocol_sequencer_core #(
   parameter int ADDR_W        = 8,
   parameter int WAIT_PRESCALE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_i,
   input  logic resume_i,
   output logic busy_o,
   output logic paused_o,
   output logic done_o,
   output logic error_o,
   protocol_sequencer_core_if.master bus
);
   localparam int CNT_W = 8 + $clog2(WAIT_PRESCALE + 1);

   typedef struct packed {
      logic [7:0] data;
      logic [3:0] cnfg;
      logic       cmd_type;
   } protocol_transfer_t;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_XFER_REQ, S_XFER_WAIT, S_WAIT, S_PAUSE
   } state_t;

   typedef enum logic [2:0] {
      OP_WAIT       = 3'd0,
      OP_COMPARE    = 3'd1,
      OP_COMP_JMP   = 3'd2,
      OP_END        = 3'd3,
      OP_PAUSE      = 3'd4,
      OP_UNCOND_JMP = 3'd5
   } opcode_t;

   state_t             state_q;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0]   wait_cnt_q;
   logic               cmp_flag_q;
   logic [7:0]         last_byte_q, prev_byte_q;
   logic               busy_q, paused_q, done_q, error_q;
   logic               prog_rd_en_q, xfer_valid_q;
   logic [3:0]         xfer_cnfg_q;
   logic [7:0]         xfer_data_q;

   protocol_transfer_t word;
   opcode_t            opcode;
   logic               mod;
   logic [ADDR_W-1:0]  pc_inc, pc_jmp;
   logic [CNT_W-1:0]   wait_total;

   assign word       = bus.prog_rdata;
   assign opcode     = opcode_t'(word.cnfg[2:0]);
   assign mod        = word.cnfg[3];
   assign pc_inc     = pc_q + ADDR_W'(1);
   assign pc_jmp     = mod ? (pc_q - ADDR_W'(word.data)) : (pc_q + ADDR_W'(word.data));
   assign wait_total = CNT_W'(word.data) * CNT_W'(WAIT_PRESCALE) - CNT_W'(1);

   always_comb begin
      pc_d = pc_q;
      case (state_q)
         S_IDLE:      if (start_i) pc_d = '0;
         S_DECODE: begin
            if (!word.cmd_type) begin
               case (opcode)
                  OP_WAIT:       if (word.data == 8'd0) pc_d = pc_inc;
                  OP_COMPARE:    pc_d = pc_inc;
                  OP_COMP_JMP:   pc_d = cmp_flag_q ? pc_jmp : pc_inc;
                  OP_UNCOND_JMP: pc_d = pc_jmp;
                  default:       pc_d = pc_q;
               endcase
            end
         end
         S_XFER_WAIT: if (bus.rsp_valid) pc_d = pc_inc;
         S_WAIT:      if (wait_cnt_q == '0) pc_d = pc_inc;
         S_PAUSE:     if (resume_i) pc_d = pc_inc;
         default:     pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         pc_q         <= '0;
         wait_cnt_q   <= '0;
         cmp_flag_q   <= 1'b0;
         last_byte_q  <= 8'd0;
         prev_byte_q  <= 8'd0;
         busy_q       <= 1'b0;
         paused_q     <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         prog_rd_en_q <= 1'b0;
         xfer_valid_q <= 1'b0;
         xfer_cnfg_q  <= 4'd0;
         xfer_data_q  <= 8'd0;
      end else begin
         pc_q         <= pc_d;
         done_q       <= 1'b0;
         prog_rd_en_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q      <= S_FETCH;
                  busy_q       <= 1'b1;
                  error_q      <= 1'b0;
                  cmp_flag_q   <= 1'b0;
                  prog_rd_en_q <= 1'b1;
               end
            end
            S_FETCH: state_q <= S_DECODE;
            S_DECODE: begin
               if (word.cmd_type) begin
                  xfer_cnfg_q  <= word.cnfg;
                  xfer_data_q  <= word.data;
                  xfer_valid_q <= 1'b1;
                  state_q      <= S_XFER_REQ;
               end else begin
                  case (opcode)
                     OP_WAIT: begin
                        if (word.data == 8'd0) begin
                           state_q      <= S_FETCH;
                           prog_rd_en_q <= 1'b1;
                        end else begin
                           wait_cnt_q <= wait_total;
                           state_q    <= S_WAIT;
                        end
                     end
                     OP_COMPARE: begin
                        cmp_flag_q   <= mod ? (last_byte_q == word.data) : (prev_byte_q == word.data);
                        state_q      <= S_FETCH;
                        prog_rd_en_q <= 1'b1;
                     end
                     OP_COMP_JMP, OP_UNCOND_JMP: begin
                        state_q      <= S_FETCH;
                        prog_rd_en_q <= 1'b1;
                     end
                     OP_END: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                     end
                     OP_PAUSE: begin
                        paused_q <= 1'b1;
                        state_q  <= S_PAUSE;
                     end
                     // Opcodes 6/7 abort the program without a done pulse.
                     default: begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                     end
                  endcase
               end
            end
            S_XFER_REQ: begin
               if (bus.xfer_ready) begin
                  xfer_valid_q <= 1'b0;
                  state_q      <= S_XFER_WAIT;
               end
            end
            S_XFER_WAIT: begin
               if (bus.rsp_valid) begin
                  prev_byte_q  <= last_byte_q;
                  last_byte_q  <= bus.rsp_data;
                  state_q      <= S_FETCH;
                  prog_rd_en_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (wait_cnt_q == '0) begin
                  state_q      <= S_FETCH;
                  prog_rd_en_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q - CNT_W'(1);
               end
            end
            S_PAUSE: begin
               if (resume_i) begin
                  paused_q     <= 1'b0;
                  state_q      <= S_FETCH;
                  prog_rd_en_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o         = busy_q;
   assign paused_o       = paused_q;
   assign done_o         = done_q;
   assign error_o        = error_q;
   assign bus.prog_rd_en = prog_rd_en_q;
   assign bus.prog_addr  = pc_q;
   assign bus.xfer_valid = xfer_valid_q;
   assign bus.xfer_cnfg  = xfer_cnfg_q;
   assign bus.xfer_data  = xfer_data_q;
endmodule

// File: tb/tb_protocol_sequencer_core.sv
// Directed bench for protocol_sequencer_core: program memory model, bus-engine responder and scoreboard queues.
module tb_protocol_sequencer_core;
   localparam int AW = 8;
   localparam int PS = 4;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic start  = 1'b0;
   logic resume = 1'b0;
   logic ready  = 1'b1;
   logic busy, paused, done, error;

   protocol_sequencer_core_if #(.ADDR_W(AW)) bus ();

   protocol_sequencer_core #(.ADDR_W(AW), .WAIT_PRESCALE(PS)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start),
      .resume_i (resume),
      .busy_o   (busy),
      .paused_o (paused),
      .done_o   (done),
      .error_o  (error),
      .bus      (bus.master)
   );

   always #5 clk = ~clk;

   logic [12:0] mem [256];
   logic [7:0]  rsp_q [$];
   int          exp_fetch [$];
   logic [11:0] exp_xfer [$];
   int n_cmp = 0, n_bad = 0;
   int n_fetch = 0, n_vld = 0, n_done = 0, cyc = 0;
   int t_fetch0 = 0, t_fetch1 = 0, t_done = 0;
   int rsp_cnt = 0;
   logic [7:0] rsp_byte = 8'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [12:0] xw(input logic [3:0] c, input logic [7:0] d);
      return {d, c, 1'b1};
   endfunction

   function automatic logic [12:0] ins(input logic [2:0] op, input logic m, input logic [7:0] opd);
      return {opd, m, op, 1'b0};
   endfunction

   assign bus.xfer_ready = ready;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.prog_rd_en) bus.prog_rdata <= mem[bus.prog_addr];
   end

   // Bus engine: responds three cycles after each accepted request.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_cnt       <= 0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= 8'd0;
      end else begin
         bus.rsp_valid <= 1'b0;
         if (bus.xfer_valid && bus.xfer_ready) begin
            rsp_cnt <= 3;
            if (rsp_q.size() != 0) rsp_byte <= rsp_q.pop_front();
            else                   rsp_byte <= 8'h00;
         end else if (rsp_cnt == 1) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= rsp_byte;
            rsp_cnt       <= 0;
         end else if (rsp_cnt > 1) begin
            rsp_cnt <= rsp_cnt - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.prog_rd_en) begin
            n_fetch++;
            if (bus.prog_addr == 8'd0) t_fetch0 = cyc;
            if (bus.prog_addr == 8'd1) t_fetch1 = cyc;
            if (exp_fetch.size() == 0) check("fetch_unexpected", 32'(bus.prog_addr), 32'hFFFF_FFFF);
            else                       check("fetch_addr", 32'(bus.prog_addr), 32'(exp_fetch.pop_front()));
         end
         if (bus.xfer_valid) begin
            n_vld++;
            if (bus.xfer_ready) begin
               if (exp_xfer.size() == 0) check("xfer_unexpected", 32'({bus.xfer_cnfg, bus.xfer_data}), 32'hFFFF_FFFF);
               else                      check("xfer_word", 32'({bus.xfer_cnfg, bus.xfer_data}), 32'(exp_xfer.pop_front()));
            end
         end
         if (done) begin
            n_done++;
            t_done = cyc;
         end
      end
   end

   task automatic run_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic end_test(input string tag);
      check({tag, "_fetch_left"}, 32'(exp_fetch.size()), 32'd0);
      check({tag, "_xfer_left"}, 32'(exp_xfer.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $error("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = ins(3'd3, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_xfer_valid", 32'(bus.xfer_valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_paused", 32'(paused), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_rd_en", 32'(bus.prog_rd_en), 32'd0);
      check("rst_addr", 32'(bus.prog_addr), 32'd0);
      check("rst_cnfg_data", 32'({bus.xfer_cnfg, bus.xfer_data}), 32'd0);

      // Single transfer then END.
      mem[0] = xw(4'b0101, 8'hA5);
      mem[1] = ins(3'd3, 1'b0, 8'h00);
      exp_fetch = {0, 1};
      exp_xfer.push_back({4'h5, 8'hA5});
      rsp_q.push_back(8'h11);
      n_vld = 0; n_done = 0;
      run_start();
      check("t1_busy_after_start", 32'(busy), 32'd1);
      wait_done("t1", 100);
      check("t1_busy_with_done", 32'(busy), 32'd0);
      check("t1_valid_cycles", 32'(n_vld), 32'd1);
      @(negedge clk);
      check("t1_done_pulse", 32'(done), 32'd0);
      check("t1_done_count", 32'(n_done), 32'd1);
      end_test("t1");

      // WAIT 3 with prescale 4.
      mem[0] = ins(3'd0, 1'b0, 8'd3);
      exp_fetch = {0, 1};
      run_start();
      wait_done("t2", 100);
      @(negedge clk);
      check("t2_fetch_gap", 32'(t_fetch1 - t_fetch0), 32'd14);
      check("t2_done_latency", 32'(t_done - t_fetch0), 32'd16);
      end_test("t2");

      // COMPARE/COMP_JMP skips the transfer when last byte matches.
      mem[0] = xw(4'b1001, 8'h00);
      mem[1] = ins(3'd1, 1'b1, 8'h3C);
      mem[2] = ins(3'd2, 1'b0, 8'd2);
      mem[3] = xw(4'b0011, 8'h77);
      mem[4] = ins(3'd3, 1'b0, 8'h00);
      exp_fetch = {0, 1, 2, 4};
      exp_xfer.push_back({4'h9, 8'h00});
      rsp_q.push_back(8'h3C);
      run_start();
      wait_done("t3a", 200);
      @(negedge clk);
      end_test("t3a");

      exp_fetch = {0, 1, 2, 3, 4};
      exp_xfer.push_back({4'h9, 8'h00});
      exp_xfer.push_back({4'h3, 8'h77});
      rsp_q.push_back(8'h3D);
      rsp_q.push_back(8'h55);
      run_start();
      wait_done("t3b", 200);
      @(negedge clk);
      end_test("t3b");

      // Poll loop exits once the read returns 01.
      mem[0] = xw(4'b1000, 8'h00);
      mem[1] = ins(3'd1, 1'b1, 8'h01);
      mem[2] = ins(3'd2, 1'b0, 8'd2);
      mem[3] = ins(3'd5, 1'b1, 8'd3);
      mem[4] = ins(3'd3, 1'b0, 8'h00);
      exp_fetch = {0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 4};
      for (int i = 0; i < 3; i++) exp_xfer.push_back({4'h8, 8'h00});
      rsp_q = {8'h05, 8'h07, 8'h01};
      n_done = 0;
      run_start();
      wait_done("t4", 400);
      @(negedge clk);
      check("t4_done_count", 32'(n_done), 32'd1);
      end_test("t4");

      // Jump below 0 and increment past 255 both wrap.
      mem[0]   = ins(3'd2, 1'b0, 8'd2);
      mem[1]   = ins(3'd5, 1'b1, 8'd3);
      mem[2]   = ins(3'd3, 1'b0, 8'h00);
      mem[254] = ins(3'd0, 1'b0, 8'd0);
      mem[255] = ins(3'd1, 1'b1, 8'h01);
      exp_fetch = {0, 1, 254, 255, 0, 2};
      run_start();
      wait_done("t5", 200);
      @(negedge clk);
      end_test("t5");

      // PAUSE at address 2 holds until resume.
      begin
         int f;
         bit seen = 1'b0;
         mem[0] = ins(3'd0, 1'b0, 8'd0);
         mem[1] = ins(3'd0, 1'b0, 8'd0);
         mem[2] = ins(3'd4, 1'b0, 8'd0);
         mem[3] = ins(3'd3, 1'b0, 8'h00);
         exp_fetch = {0, 1, 2, 3};
         run_start();
         for (int k = 0; k < 50; k++) begin
            if (paused) begin
               seen = 1'b1;
               break;
            end
            @(negedge clk);
         end
         check("t6_paused_seen", 32'(seen), 32'd1);
         f = n_fetch;
         repeat (10) @(negedge clk);
         check("t6_no_fetch", 32'(n_fetch), 32'(f));
         check("t6_paused_hold", 32'(paused), 32'd1);
         check("t6_busy_hold", 32'(busy), 32'd1);
         resume = 1'b1;
         @(negedge clk);
         resume = 1'b0;
         wait_done("t6", 50);
         @(negedge clk);
         check("t6_paused_clear", 32'(paused), 32'd0);
         end_test("t6");
      end

      // Unused opcode sets sticky error, next start clears it.
      begin
         bit idle = 1'b0;
         mem[0] = ins(3'd7, 1'b0, 8'h00);
         exp_fetch = {0};
         n_done = 0;
         run_start();
         for (int k = 0; k < 20; k++) begin
            if (!busy) begin
               idle = 1'b1;
               break;
            end
            @(negedge clk);
         end
         check("t7_busy_fell", 32'(idle), 32'd1);
         check("t7_error_set", 32'(error), 32'd1);
         repeat (3) @(negedge clk);
         check("t7_no_done", 32'(n_done), 32'd0);
         check("t7_error_sticky", 32'(error), 32'd1);
         end_test("t7");
         mem[0] = ins(3'd3, 1'b0, 8'h00);
         exp_fetch = {0};
         run_start();
         check("t7_error_cleared", 32'(error), 32'd0);
         wait_done("t7b", 20);
         @(negedge clk);
         end_test("t7b");
      end

      // Asynchronous reset while a request is pending.
      begin
         bit vld = 1'b0;
         mem[0] = xw(4'hC, 8'h3E);
         ready = 1'b0;
         exp_fetch = {0};
         run_start();
         for (int k = 0; k < 20; k++) begin
            if (bus.xfer_valid) begin
               vld = 1'b1;
               break;
            end
            @(negedge clk);
         end
         check("t8_valid_seen", 32'(vld), 32'd1);
         check("t8_req_word", 32'({bus.xfer_cnfg, bus.xfer_data}), 32'h0C3E);
         #2 rst_n = 1'b0;
         #1;
         check("t8_valid_async", 32'(bus.xfer_valid), 32'd0);
         check("t8_busy_async", 32'(busy), 32'd0);
         check("t8_word_async", 32'({bus.xfer_cnfg, bus.xfer_data}), 32'd0);
         @(negedge clk);
         rst_n = 1'b1;
         ready = 1'b1;
         repeat (3) @(negedge clk);
         check("t8_idle_after", 32'({busy, bus.prog_rd_en, bus.xfer_valid}), 32'd0);
         end_test("t8");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
